// File: rtl/stream_demux.sv
// Registered 1-to-2 valid/ready demultiplexer with one holding slot per output.
// Define STREAM_DEMUX_COUNT_EN to build the per-output transfer counters.
module stream_demux #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 select,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [WIDTH-1:0]     out0_data,
    output logic [CNT_WIDTH-1:0] out0_count,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic [WIDTH-1:0]     out1_data,
    output logic [CNT_WIDTH-1:0] out1_count
);

    logic [1:0] out_ready;
    logic [1:0] slot_valid;
    logic [1:0] slot_drain;
    logic       accept;

    assign out_ready = {out1_ready, out0_ready};

    // Only the addressed slot decides readiness, so a stalled output never blocks the other.
    assign in_ready = !slot_valid[select] || out_ready[select];
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic             fill;
            logic             valid_q;
            logic             valid_d;
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;

            assign fill           = accept && (select == gi[0]);
            assign slot_drain[gi] = valid_q && out_ready[gi];
            assign slot_valid[gi] = valid_q;

            // A fill in the same cycle as a drain keeps the slot occupied with the new word.
            assign valid_d = fill || (valid_q && !slot_drain[gi]);
            assign data_d  = fill ? in_data : data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

`ifdef STREAM_DEMUX_COUNT_EN
            logic [CNT_WIDTH-1:0] count_q;
            logic [CNT_WIDTH-1:0] count_d;

            assign count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, slot_drain[gi]};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end
`endif
        end
    endgenerate

    assign out0_valid = g_slot[0].valid_q;
    assign out1_valid = g_slot[1].valid_q;
    assign out0_data  = g_slot[0].data_q;
    assign out1_data  = g_slot[1].data_q;

`ifdef STREAM_DEMUX_COUNT_EN
    assign out0_count = g_slot[0].count_q;
    assign out1_count = g_slot[1].count_q;
`else
    assign out0_count = '0;
    assign out1_count = '0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux: routing, stalls, no-bubble refill, streaming, async reset.
module tb_stream_demux;

    localparam int WIDTH     = 16;
    localparam int CNT_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 select = 1'b0;
    logic [WIDTH-1:0]     in_data = '0;
    logic                 out0_valid;
    logic                 out0_ready = 1'b0;
    logic [WIDTH-1:0]     out0_data;
    logic [CNT_WIDTH-1:0] out0_count;
    logic                 out1_valid;
    logic                 out1_ready = 1'b0;
    logic [WIDTH-1:0]     out1_data;
    logic [CNT_WIDTH-1:0] out1_count;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    stream_demux #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .select     (select),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_count (out0_count),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_count (out1_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Expected counter value: transfers modulo 2^CNT_WIDTH, or 0 when counters are not built.
    function automatic logic [31:0] cnt_exp(input int n);
`ifdef STREAM_DEMUX_COUNT_EN
        return 32'(n % 256);
`else
        return 32'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        check("rst_out0_valid", 32'(out0_valid), 32'd0);
        check("rst_out1_valid", 32'(out1_valid), 32'd0);
        check("rst_out0_data",  32'(out0_data),  32'd0);
        check("rst_out1_data",  32'(out1_data),  32'd0);
        check("rst_counts",     32'({out1_count, out0_count}), 32'd0);
        check("rst_in_ready",   32'(in_ready),   32'd1);

        // Single word to output 0, consumer ready
        select = 1'b0; in_data = 16'd1; in_valid = 1'b1; out0_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("t1_out0_valid", 32'(out0_valid), 32'd1);
        check("t1_out0_data",  32'(out0_data),  32'd1);
        check("t1_out1_valid", 32'(out1_valid), 32'd0);
        step();
        check("t1_out0_valid_drop", 32'(out0_valid), 32'd0);
        check("t1_out0_data_hold",  32'(out0_data),  32'd1);
        check("t1_out0_count",      32'(out0_count), cnt_exp(1));

        // Single word to output 1, consumed one cycle later
        select = 1'b1; in_data = 16'd2; in_valid = 1'b1; out1_ready = 1'b0;
        step();
        in_valid = 1'b0; out1_ready = 1'b1;
        check("t2_out1_valid", 32'(out1_valid), 32'd1);
        check("t2_out1_data",  32'(out1_data),  32'd2);
        check("t2_out0_data",  32'(out0_data),  32'd1);
        step();
        check("t2_out1_valid_drop", 32'(out1_valid), 32'd0);
        check("t2_out1_count",      32'(out1_count), cnt_exp(1));

        // Stall output 0 with a full slot
        out0_ready = 1'b0; select = 1'b0; in_data = 16'hAAAA; in_valid = 1'b1;
        step();
        check("t3_out0_data_first", 32'(out0_data),  32'hAAAA);
        check("t3_out0_valid",      32'(out0_valid), 32'd1);
        in_data = 16'h5555;
        #1;
        check("t3_in_ready_blocked", 32'(in_ready), 32'd0);
        step();
        check("t3_slot_holds", 32'(out0_data), 32'hAAAA);
        check("t3_in_ready_still_blocked", 32'(in_ready), 32'd0);

        // Output 1 stays usable while output 0 is stalled
        select = 1'b1; in_data = 16'h1234;
        #1;
        check("t4_in_ready_other", 32'(in_ready), 32'd1);
        step();
        check("t4_out1_valid", 32'(out1_valid), 32'd1);
        check("t4_out1_data",  32'(out1_data),  32'h1234);
        check("t4_out0_unchanged", 32'(out0_data), 32'hAAAA);

        // Release output 0: AAAA drains while 5555 fills in the same edge
        select = 1'b0; in_data = 16'h5555;
        #1;
        check("t3_in_ready_held", 32'(in_ready), 32'd0);
        out0_ready = 1'b1;
        #1;
        check("t3_in_ready_release", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("t3_nobubble_valid", 32'(out0_valid), 32'd1);
        check("t3_nobubble_data",  32'(out0_data),  32'h5555);
        check("t3_out0_count",     32'(out0_count), cnt_exp(2));
        check("t4_out1_drained",   32'(out1_valid), 32'd0);
        check("t4_out1_count",     32'(out1_count), cnt_exp(2));
        step();
        check("t3_out0_final_valid", 32'(out0_valid), 32'd0);
        check("t3_out0_final_count", 32'(out0_count), cnt_exp(3));

        // Back-to-back stream of 300 words to output 1 from a fresh reset
        do_reset();
        out1_ready = 1'b1; select = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = 16'(16'h3000 + i);
            step();
            check($sformatf("t5_word%0d", i), 32'({out1_valid, out1_data}), 32'({1'b1, 16'(16'h3000 + i)}));
        end
        in_valid = 1'b0;
        step();
        check("t5_out1_valid_end", 32'(out1_valid), 32'd0);
        check("t5_out1_count",     32'(out1_count), cnt_exp(300));
        check("t5_out0_count",     32'(out0_count), cnt_exp(0));

        // Fill both slots, then assert reset mid-cycle
        out0_ready = 1'b0; out1_ready = 1'b0;
        select = 1'b0; in_data = 16'h00F0; in_valid = 1'b1;
        step();
        select = 1'b1; in_data = 16'h0F00;
        step();
        in_valid = 1'b0;
        check("t6_both_valid", 32'({out1_valid, out0_valid}), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valids", 32'({out1_valid, out0_valid}), 32'd0);
        check("t6_async_data",   32'({out1_data, out0_data}),   32'd0);
        check("t6_async_counts", 32'({out1_count, out0_count}), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("t6_in_ready_after", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks_cnt);
        $fatal(1, "timeout");
    end

endmodule
